// File: rtl/cfg_frame_pkg.sv
// Shared definitions for the column configuration path.
// Covers the header word layout and the frame sequencer state encoding.
package cfg_frame_pkg;

    localparam logic [7:0] HDR_MAGIC     = 8'hFA;
    localparam int         HDR_MAGIC_LSB = 24;
    localparam int         HDR_COL_LSB   = 16;
    localparam int         HDR_IDX_LSB   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] magic;
        logic [7:0] column;
        logic [7:0] index;
    } header_t;

    function automatic header_t decode_header(input logic [31:0] word);
        header_t h;
        h.magic  = word[HDR_MAGIC_LSB +: 8];
        h.column = word[HDR_COL_LSB   +: 8];
        h.index  = word[HDR_IDX_LSB   +: 8];
        return h;
    endfunction

endpackage

// File: rtl/frame_row_buffer.sv
// Per-row FrameData holding registers for one column.
// A write updates a single row; the other rows keep their contents.
module frame_row_buffer #(
    parameter int unsigned NumRows         = 8,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned RowW            = (NumRows > 1) ? $clog2(NumRows) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [RowW-1:0]                    row,
    input  logic [FrameBitsPerRow-1:0]         wdata,
    output logic [NumRows*FrameBitsPerRow-1:0] data
);

    logic [FrameBitsPerRow-1:0] rows [NumRows];

    // NOTE: this array feeds tile outputs directly, so it is reset like any
    // other flop; unreset storage would drive X onto FrameData after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NumRows); i++) begin
                rows[i] <= '0;
            end
        end else if (we) begin
            rows[row] <= wdata;
        end
    end

    for (genvar r = 0; r < int'(NumRows); r++) begin : g_flat
        assign data[r*FrameBitsPerRow +: FrameBitsPerRow] = rows[r];
    end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Column frame-write sequencer: takes a header plus one word per row,
// loads the FrameData rows, then pulses the addressed FrameStrobe line.
module frame_strobe_sequencer
    import cfg_frame_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumRows         = 8,
    parameter int unsigned StrobeCycles    = 2,
    parameter logic [7:0]  ColumnId        = 8'd0
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [FrameBitsPerRow-1:0]         s_data,
    input  logic                               abort,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               err,
    output logic [15:0]                        frames_written
);

    localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned StbW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
    localparam logic [StbW-1:0] LastStb = StbW'(StrobeCycles - 1);

    state_t                     state_q, state_d;
    logic [RowW-1:0]            row_q, row_d;
    logic [StbW-1:0]            stb_q, stb_d;
    logic [7:0]                 idx_q, idx_d;
    logic                       hit_q, hit_d;
    logic                       err_d;
    logic [15:0]                fw_q, fw_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       buf_we;
    logic                       accept;
    logic                       col_match;
    logic                       idx_ok;
    header_t                    hdr;

    assign hdr       = decode_header(s_data[31:0]);
    assign col_match = (hdr.column == ColumnId);
    assign idx_ok    = (32'(hdr.index) < MaxFramesPerCol);
    assign accept    = s_valid && s_ready;

    // NOTE: every flop uses <=, so all registers sample the pre-edge values
    // and the order of statements inside a clocked block cannot matter.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output is given a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        stb_d   = stb_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        fw_d    = fw_q;
        err_d   = 1'b0;
        buf_we  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            row_d   = '0;
            stb_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hdr.magic != HDR_MAGIC) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                            idx_d   = hdr.index;
                            hit_d   = col_match && idx_ok;
                            err_d   = col_match && !idx_ok;
                            row_d   = '0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        buf_we = hit_q;
                        if (row_q == LastRow) begin
                            row_d   = '0;
                            stb_d   = '0;
                            state_d = hit_q ? STROBE : IDLE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (stb_q == LastStb) begin
                        stb_d   = '0;
                        state_d = GAP;
                    end else begin
                        stb_d = stb_q + 1'b1;
                    end
                end
                GAP: begin
                    fw_d    = fw_q + 16'd1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Strobe is registered from the next state so it tracks STROBE exactly.
        strobe_d = '0;
        for (int i = 0; i < int'(MaxFramesPerCol); i++) begin
            strobe_d[i] = (state_d == STROBE) && (idx_q == 8'(i));
        end
    end

    always_comb begin
        s_ready = ((state_q == IDLE) || (state_q == LOAD)) && !abort;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            row_q    <= '0;
            stb_q    <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            fw_q     <= '0;
            err      <= 1'b0;
            strobe_q <= '0;
        end else begin
            row_q    <= row_d;
            stb_q    <= stb_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            fw_q     <= fw_d;
            err      <= err_d;
            strobe_q <= strobe_d;
        end
    end

    assign FrameStrobe    = strobe_q;
    assign frames_written = fw_q;

    frame_row_buffer #(
        .NumRows         (NumRows),
        .FrameBitsPerRow (FrameBitsPerRow),
        .RowW            (RowW)
    ) u_rows (
        .clk   (CLK),
        .rst_n (resetn),
        .we    (buf_we),
        .row   (row_q),
        .wdata (s_data),
        .data  (FrameData)
    );

endmodule
